// File: rtl/fft_peak_detector_if.sv
// Magnitude stream from the FFT magnitude stage into the peak detector.
interface fft_peak_detector_if #(
  parameter int DATA_WIDTH = 21
);
  logic                  mag_valid;
  logic                  mag_sop;
  logic                  mag_eop;
  logic [DATA_WIDTH-1:0] mag_data;

  modport master (output mag_valid, output mag_sop, output mag_eop, output mag_data);
  modport slave  (input  mag_valid, input  mag_sop, input  mag_eop, input  mag_data);
endinterface

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over the lower half of an FFT magnitude spectrum,
// skipping the lowest bins, with framing checks and a published-frame counter.
module fft_peak_detector #(
  parameter int DATA_WIDTH = 21,
  parameter int BIN_WIDTH  = 13,
  parameter int FFT_LEN    = 4096,
  parameter int SKIP_BINS  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fft_peak_detector_if.slave     mag,
  output logic [BIN_WIDTH-1:0]   peak_bin,
  output logic [DATA_WIDTH-1:0]  peak_mag,
  output logic                   peak_valid,
  output logic                   frame_error,
  output logic [15:0]            frame_count
);

  localparam logic [BIN_WIDTH-1:0] LAST_BIN  = BIN_WIDTH'(FFT_LEN - 1);
  localparam logic [BIN_WIDTH-1:0] HALF_LAST = BIN_WIDTH'(FFT_LEN / 2 - 1);
  localparam logic [BIN_WIDTH-1:0] SKIP      = BIN_WIDTH'(SKIP_BINS);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [BIN_WIDTH-1:0]  bin_cnt_q, bin_cnt_d;
  logic [BIN_WIDTH-1:0]  max_bin_q, max_bin_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [BIN_WIDTH-1:0]  peak_bin_q, peak_bin_d;
  logic [DATA_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic                  peak_valid_q, peak_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic [BIN_WIDTH-1:0]  beat_idx;
  logic [DATA_WIDTH-1:0] run_max;
  logic                  in_window;
  logic                  beat_wins;

  always_comb begin
    // A sop beat is always bin 0 and compares against a freshly cleared max.
    beat_idx  = mag.mag_sop ? '0 : bin_cnt_q;
    run_max   = mag.mag_sop ? '0 : max_q;
    in_window = (beat_idx >= SKIP) && (beat_idx <= HALF_LAST);
    beat_wins = in_window && (mag.mag_data > run_max);

    state_d       = state_q;
    bin_cnt_d     = bin_cnt_q;
    max_bin_d     = max_bin_q;
    max_d         = max_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    peak_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    frame_count_d = frame_count_q;

    if (mag.mag_valid) begin
      if (mag.mag_sop && mag.mag_eop) begin
        frame_error_d = 1'b1;
        state_d       = IDLE;
        bin_cnt_d     = '0;
        max_d         = '0;
        max_bin_d     = '0;
      end else if (mag.mag_sop) begin
        frame_error_d = (state_q == ACTIVE);
        state_d       = ACTIVE;
        bin_cnt_d     = BIN_WIDTH'(1);
        max_d         = beat_wins ? mag.mag_data : '0;
        max_bin_d     = '0;
      end else if (state_q == ACTIVE) begin
        if (mag.mag_eop || (bin_cnt_q == LAST_BIN)) begin
          state_d   = IDLE;
          bin_cnt_d = '0;
          max_d     = '0;
          max_bin_d = '0;
          if (mag.mag_eop && (bin_cnt_q == LAST_BIN)) begin
            // An all-zero window never triggers a strict update, so report the first searched bin.
            peak_bin_d    = (max_q == '0) ? SKIP : max_bin_q;
            peak_mag_d    = max_q;
            peak_valid_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          bin_cnt_d = bin_cnt_q + BIN_WIDTH'(1);
          if (beat_wins) begin
            max_d     = mag.mag_data;
            max_bin_d = bin_cnt_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bin_cnt_q     <= '0;
      max_bin_q     <= '0;
      max_q         <= '0;
      peak_bin_q    <= '0;
      peak_mag_q    <= '0;
      peak_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bin_cnt_q     <= bin_cnt_d;
      max_bin_q     <= max_bin_d;
      max_q         <= max_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      peak_valid_q  <= peak_valid_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign peak_valid  = peak_valid_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector with a 16-bin frame and DC skip of 1.
module tb_fft_peak_detector;

  localparam int DW   = 21;
  localparam int BW   = 13;
  localparam int N    = 16;
  localparam int SKIP = 1;

  typedef struct {
    bit          is_pub;
    int unsigned bin;
    int unsigned mag;
    int unsigned cnt;
    int unsigned due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BW-1:0] peak_bin;
  logic [DW-1:0] peak_mag;
  logic          peak_valid;
  logic          frame_error;
  logic [15:0]   frame_count;

  fft_peak_detector_if #(.DATA_WIDTH(DW)) mag_bus ();

  fft_peak_detector #(
    .DATA_WIDTH(DW),
    .BIN_WIDTH (BW),
    .FFT_LEN   (N),
    .SKIP_BINS (SKIP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mag        (mag_bus.slave),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .frame_error(frame_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_count = 0;
  int unsigned last_bin = 0;
  int unsigned last_mag = 0;
  int unsigned ref_bin, ref_mag;
  int unsigned frm[N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference peak: first strictly-greatest bin in [SKIP, N/2-1], SKIP/0 when all zero.
  function automatic void ref_peak();
    ref_bin = SKIP;
    ref_mag = 0;
    for (int i = SKIP; i < N / 2; i++)
      if (frm[i] > ref_mag) begin
        ref_mag = frm[i];
        ref_bin = i;
      end
  endfunction

  // kind: 0 = no outcome, 1 = publish expected next cycle, 2 = frame error expected next cycle
  task automatic beat(input bit v, input bit s, input bit e, input int unsigned d, input int kind);
    exp_t x;
    mag_bus.mag_valid = v;
    mag_bus.mag_sop   = s;
    mag_bus.mag_eop   = e;
    mag_bus.mag_data  = DW'(d);
    if (kind == 1) begin
      exp_count = (exp_count + 1) & 32'hFFFF;
      last_bin  = ref_bin;
      last_mag  = ref_mag;
      x = '{1'b1, ref_bin, ref_mag, exp_count, cyc + 1};
      sb.push_back(x);
    end else if (kind == 2) begin
      x = '{1'b0, last_bin, last_mag, exp_count, cyc + 1};
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic send_frame(input bit gaps);
    ref_peak();
    for (int i = 0; i < N; i++) begin
      beat(1'b1, i == 0, i == N - 1, frm[i], (i == N - 1) ? 1 : 0);
      if (gaps && i != N - 1) beat(1'b0, 1'b0, 1'b0, 32'h1FFFFF, 0);
    end
    idle(1);
  endtask

  task automatic fill(input int unsigned v);
    for (int i = 0; i < N; i++) frm[i] = v;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check_eq("missing_pulse", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (peak_valid || frame_error) begin
        check_eq("pulse_exclusive", peak_valid & frame_error, 0);
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", {peak_valid, frame_error}, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("latency", cyc, mon_e.due);
          check_eq("pulse_kind", peak_valid, mon_e.is_pub);
          check_eq("peak_bin", peak_bin, mon_e.bin);
          check_eq("peak_mag", peak_mag, mon_e.mag);
          check_eq("frame_count", frame_count, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mag_bus.mag_valid = 1'b0;
    mag_bus.mag_sop   = 1'b0;
    mag_bus.mag_eop   = 1'b0;
    mag_bus.mag_data  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_peak_bin", peak_bin, 0);
    check_eq("rst_peak_mag", peak_mag, 0);
    check_eq("rst_peak_valid", peak_valid, 0);
    check_eq("rst_frame_error", frame_error, 0);
    check_eq("rst_frame_count", frame_count, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Non-sop beats in IDLE, including a stray eop, are ignored.
    beat(1'b1, 1'b0, 1'b0, 123, 0);
    beat(1'b1, 1'b0, 1'b1, 55, 0);
    beat(1'b1, 1'b0, 1'b0, 4000, 0);
    idle(2);

    fill(10); frm[3] = 500;
    send_frame(1'b0);
    idle(3);
    check_eq("hold_bin", peak_bin, 3);
    check_eq("hold_mag", peak_mag, 500);

    fill(0); frm[0] = 9000; frm[5] = 200; frm[9] = 9999;
    send_frame(1'b0);

    fill(0); frm[2] = 300; frm[6] = 300;
    send_frame(1'b1);

    fill(0);
    send_frame(1'b0);

    fill(0); frm[7] = 2097151; frm[1] = 2097150;
    send_frame(1'b0);

    // Early eop at bin 10.
    for (int i = 0; i <= 10; i++) beat(1'b1, i == 0, i == 10, (i == 2) ? 8000 : 1, (i == 10) ? 2 : 0);
    idle(1);
    // New frame interrupted by sop at bin 4, which restarts and completes.
    fill(5); frm[6] = 650; frm[2] = 649;
    ref_peak();
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0, 1'b0, (i == 1) ? 7000 : 1, 0);
    beat(1'b1, 1'b1, 1'b0, frm[0], 2);
    for (int i = 1; i < N; i++) beat(1'b1, 1'b0, i == N - 1, frm[i], (i == N - 1) ? 1 : 0);
    idle(2);

    // Missing eop at the last bin.
    for (int i = 0; i < N; i++) beat(1'b1, i == 0, 1'b0, 20000, (i == N - 1) ? 2 : 0);
    idle(1);
    check_eq("err_hold_bin", peak_bin, 6);
    check_eq("err_hold_mag", peak_mag, 650);

    beat(1'b1, 1'b1, 1'b1, 5, 2);
    idle(2);

    // Asynchronous reset mid-frame discards the partial frame.
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b0, 3000, 0);
    mag_bus.mag_valid = 1'b1;
    mag_bus.mag_sop   = 1'b0;
    mag_bus.mag_eop   = 1'b0;
    mag_bus.mag_data  = DW'(3000);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_peak_bin", peak_bin, 0);
    check_eq("midrst_peak_mag", peak_mag, 0);
    check_eq("midrst_peak_valid", peak_valid, 0);
    check_eq("midrst_frame_error", frame_error, 0);
    check_eq("midrst_frame_count", frame_count, 0);
    exp_count = 0;
    last_bin  = 0;
    last_mag  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 8; i < N; i++) beat(1'b1, 1'b0, i == N - 1, 3000, 0);
    idle(1);
    fill(0); frm[4] = 77;
    send_frame(1'b0);

    // Preload the counter to its wrap point, then publish once more.
    force dut.frame_count_q = 16'hFFFF;
    idle(1);
    release dut.frame_count_q;
    idle(1);
    check_eq("preload_count", frame_count, 16'hFFFF);
    exp_count = 32'hFFFF;
    fill(1); frm[7] = 42;
    send_frame(1'b0);
    check_eq("wrap_count", frame_count, 0);

    idle(4);
    check_eq("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
